// File: rtl/nzp_cc_unit.sv
// nzp_cc_unit
//   Registered LC-3 condition-code unit. Classifies a WIDTH-bit result bus
//   into one-hot {N,Z,P}, holds it in the CC register under LD_CC, and
//   evaluates the branch-enable flag from IR[11:9] under LD_BEN.
//   PIPE=1 inserts an input stage (D_in/UNSIGNED/LD_CC) ahead of the
//   classifier for timing on wide buses; the CC update then lands one
//   cycle later and cc_busy flags the in-flight update.
//
// Ports
//   Clk       in   rising-edge clock
//   Reset_n   in   asynchronous active-low reset
//   D_in      in   [WIDTH-1:0] result bus value to classify
//   LD_CC     in   load CC register from D_in
//   UNSIGNED  in   1 = classify D_in as unsigned (N never set)
//   IR_nzp    in   [2:0] branch condition mask {n,z,p}
//   LD_BEN    in   load BEN register
//   NZP_out   out  [2:0] registered {N,Z,P}, always one-hot
//   BEN       out  registered branch-enable
//   cc_busy   out  PIPE=1: update captured but not yet committed; else 0
module nzp_cc_unit #(
    parameter int         WIDTH    = 16,
    parameter int         PIPE     = 0,
    parameter logic [2:0] CC_RESET = 3'b010
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] D_in,
    input  logic             LD_CC,
    input  logic             UNSIGNED,
    input  logic [2:0]       IR_nzp,
    input  logic             LD_BEN,
    output logic [2:0]       NZP_out,
    output logic             BEN,
    output logic             cc_busy
);

    // Classifier input: either the raw bus or the registered stage.
    logic [WIDTH-1:0] stg_d;
    logic             stg_uns;
    logic             stg_ld;

    generate
        if (PIPE != 0) begin : g_pipe
            logic [WIDTH-1:0] d_q;
            logic             uns_q;
            logic             pend_q;

            // The pending bit tracks LD_CC every cycle, so back-to-back
            // loads commit one per cycle in order and nothing is dropped.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    d_q    <= '0;
                    uns_q  <= 1'b0;
                    pend_q <= 1'b0;
                end else begin
                    pend_q <= LD_CC;
                    d_q    <= D_in;
                    uns_q  <= UNSIGNED;
                end
            end

            assign stg_d   = d_q;
            assign stg_uns = uns_q;
            assign stg_ld  = pend_q;
            assign cc_busy = pend_q;
        end else begin : g_direct
            assign stg_d   = D_in;
            assign stg_uns = UNSIGNED;
            assign stg_ld  = LD_CC;
            assign cc_busy = 1'b0;
        end
    endgenerate

    // One-hot by construction: Z wins on zero, N only for signed with MSB
    // set, P covers everything else (incl. MSB-only value in unsigned mode).
    logic [2:0] nzp_new;

    always_comb begin
        nzp_new = 3'b001;
        if (stg_d == '0)
            nzp_new = 3'b010;
        else if (!stg_uns && stg_d[WIDTH-1])
            nzp_new = 3'b100;
    end

    logic [2:0] nzp_q;
    logic       ben_q;

    // BEN reads nzp_q before this edge's CC commit, matching the LC-3
    // FSM ordering where BEN is evaluated from the previous instruction.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            nzp_q <= CC_RESET;
            ben_q <= 1'b0;
        end else begin
            if (stg_ld)
                nzp_q <= nzp_new;
            if (LD_BEN)
                ben_q <= |(IR_nzp & nzp_q);
        end
    end

    assign NZP_out = nzp_q;
    assign BEN     = ben_q;

endmodule

// File: tb/tb_nzp_cc_unit.sv
// Testbench for nzp_cc_unit: three instances
//   u0 WIDTH=16 PIPE=0, u1 WIDTH=16 PIPE=1, u2 WIDTH=32 PIPE=0.
// Expected outputs are queued with the cycle they become due and compared
// by a negedge monitor.
module tb_nzp_cc_unit;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [31:0] d      [3];
    logic        ld_cc  [3];
    logic        uns    [3];
    logic [2:0]  ir     [3];
    logic        ld_ben [3];
    logic [2:0]  nzp    [3];
    logic        ben    [3];
    logic        busy   [3];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        int         u;
        int         sel;   // 0 = NZP_out, 1 = BEN, 2 = cc_busy
        int         due;
        logic [2:0] v;
    } exp_t;
    exp_t sb[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    nzp_cc_unit #(.WIDTH(16), .PIPE(0), .CC_RESET(3'b010)) u0 (
        .Clk(Clk), .Reset_n(Reset_n), .D_in(d[0][15:0]), .LD_CC(ld_cc[0]),
        .UNSIGNED(uns[0]), .IR_nzp(ir[0]), .LD_BEN(ld_ben[0]),
        .NZP_out(nzp[0]), .BEN(ben[0]), .cc_busy(busy[0]));

    nzp_cc_unit #(.WIDTH(16), .PIPE(1), .CC_RESET(3'b010)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .D_in(d[1][15:0]), .LD_CC(ld_cc[1]),
        .UNSIGNED(uns[1]), .IR_nzp(ir[1]), .LD_BEN(ld_ben[1]),
        .NZP_out(nzp[1]), .BEN(ben[1]), .cc_busy(busy[1]));

    nzp_cc_unit #(.WIDTH(32), .PIPE(0), .CC_RESET(3'b010)) u2 (
        .Clk(Clk), .Reset_n(Reset_n), .D_in(d[2]), .LD_CC(ld_cc[2]),
        .UNSIGNED(uns[2]), .IR_nzp(ir[2]), .LD_BEN(ld_ben[2]),
        .NZP_out(nzp[2]), .BEN(ben[2]), .cc_busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference classifier written from the definition of N/Z/P.
    function automatic logic [2:0] ref_nzp(input logic [31:0] v, input int w, input logic un);
        if (v == 0) return 3'b010;
        if (!un && v[w-1]) return 3'b100;
        return 3'b001;
    endfunction

    function automatic logic [2:0] get_out(input int u, input int sel);
        case (sel)
            0:       return nzp[u];
            1:       return {2'b00, ben[u]};
            default: return {2'b00, busy[u]};
        endcase
    endfunction

    always @(negedge Clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk(sb[i].tag, {29'd0, get_out(sb[i].u, sb[i].sel)}, {29'd0, sb[i].v});
                sb.delete(i);
            end
        end
    end

    task automatic ex(input string tag, input int u, input int sel, input int lat, input logic [2:0] v);
        exp_t e;
        e.tag = tag; e.u = u; e.sel = sel; e.due = cyc + lat; e.v = v;
        sb.push_back(e);
    endtask

    task automatic clr_all();
        for (int i = 0; i < 3; i++) begin
            ld_cc[i] = 1'b0; uns[i] = 1'b0; ld_ben[i] = 1'b0; ir[i] = 3'b000;
        end
    endtask

    task automatic drv(input int u, input logic [31:0] v, input logic ldc,
                       input logic un, input logic ldb, input logic [2:0] irv);
        d[u] = v; ld_cc[u] = ldc; uns[u] = un; ld_ben[u] = ldb; ir[u] = irv;
    endtask

    task automatic step();
        @(negedge Clk);
        clr_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        logic        ru;
        logic [31:0] wvals [3];
        clr_all();
        for (int i = 0; i < 3; i++) d[i] = '0;

        // Reset values
        repeat (2) @(negedge Clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_nzp", {29'd0, nzp[i]}, 32'h2);
            chk("rst_ben", {31'd0, ben[i]}, 32'h0);
            chk("rst_busy", {31'd0, busy[i]}, 32'h0);
        end
        Reset_n = 1'b1;
        step();

        // Signed classify, PIPE=0
        drv(0, 32'h8000, 1, 0, 0, 3'b000); ex("s_msb_n", 0, 0, 1, 3'b100); step();
        drv(0, 32'h0000, 1, 0, 0, 3'b000); ex("s_zero",  0, 0, 1, 3'b010); step();
        drv(0, 32'h0001, 1, 0, 0, 3'b000); ex("s_one_p", 0, 0, 1, 3'b001); step();
        // D_in activity without LD_CC must not move the CC register
        for (int i = 0; i < 3; i++) begin
            drv(0, $urandom_range(0, 65535), 0, 0, 0, 3'b000);
            ex("hold", 0, 0, 1, 3'b001); step();
        end

        // Unsigned mode
        drv(0, 32'hFFFF, 1, 1, 0, 3'b000); ex("u_ffff", 0, 0, 1, 3'b001); step();
        drv(0, 32'h0000, 1, 1, 0, 3'b000); ex("u_zero", 0, 0, 1, 3'b010); step();
        drv(0, 32'h8000, 1, 1, 0, 3'b000); ex("u_msb",  0, 0, 1, 3'b001); step();

        // BEN ordering: BEN sees NZP before the simultaneous CC commit
        drv(0, 32'h0001, 1, 0, 0, 3'b000); ex("b_pre", 0, 0, 1, 3'b001); step();
        drv(0, 32'h8000, 1, 0, 1, 3'b001);
        ex("b_old_nzp", 0, 1, 1, 3'b001); ex("b_new_cc", 0, 0, 1, 3'b100); step();
        drv(0, 32'h0000, 0, 0, 1, 3'b001); ex("b_p_miss", 0, 1, 1, 3'b000); step();
        drv(0, 32'h0000, 0, 0, 1, 3'b100); ex("b_n_hit",  0, 1, 1, 3'b001); step();
        drv(0, 32'h0000, 0, 0, 1, 3'b000); ex("b_ir000",  0, 1, 1, 3'b000); step();
        drv(0, 32'h0000, 0, 0, 1, 3'b111); ex("b_ir111",  0, 1, 1, 3'b001); step();
        drv(0, 32'h0000, 0, 0, 0, 3'b000); ex("b_hold",   0, 1, 1, 3'b001); step();

        // Random classify on u0
        for (int i = 0; i < 8; i++) begin
            rv = {16'd0, 16'($urandom_range(0, 65535))};
            if (i == 0) rv = 32'h0;
            if (i == 1) rv = 32'h7FFF;
            ru = 1'($urandom_range(0, 1));
            drv(0, rv, 1, ru, 0, 3'b000); ex("rnd", 0, 0, 1, ref_nzp(rv, 16, ru)); step();
        end

        // PIPE=1 back-to-back loads
        drv(1, 32'h0005, 1, 0, 0, 3'b000);
        ex("p_busy0", 1, 2, 1, 3'b001); ex("p_cc0", 1, 0, 2, 3'b001); step();
        drv(1, 32'h0000, 1, 0, 0, 3'b000);
        ex("p_busy1", 1, 2, 1, 3'b001); ex("p_cc1", 1, 0, 2, 3'b010); step();
        drv(1, 32'hFFFD, 1, 0, 0, 3'b000);
        ex("p_busy2", 1, 2, 1, 3'b001); ex("p_cc2", 1, 0, 2, 3'b100); step();
        drv(1, 32'h0000, 0, 0, 0, 3'b000);
        ex("p_idle_busy", 1, 2, 1, 3'b000); ex("p_idle_hold", 1, 0, 2, 3'b100); step();
        // Isolated load after a gap
        drv(1, 32'h0001, 1, 0, 0, 3'b000);
        ex("p_gap_busy", 1, 2, 1, 3'b001); ex("p_gap_pre", 1, 0, 1, 3'b100);
        ex("p_gap_cc", 1, 0, 2, 3'b001); step();
        drv(1, 32'h8000, 0, 0, 0, 3'b000); ex("p_gap_clr", 1, 2, 1, 3'b000); step();

        // WIDTH=32: classify, and IR=111 loads 1 whatever the NZP is
        wvals[0] = 32'h0001_0000; wvals[1] = 32'h0000_0000; wvals[2] = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            drv(2, wvals[i], 1, 0, 1, 3'b000);
            ex("w_ben0", 2, 1, 1, 3'b000); ex("w_cc", 2, 0, 1, ref_nzp(wvals[i], 32, 1'b0)); step();
            drv(2, 32'h0, 0, 0, 1, 3'b111); ex("w_ben111", 2, 1, 1, 3'b001); step();
        end

        repeat (3) step();
        chk("sb_drain1", sb.size(), 0);

        // Reset mid-pipeline: pending update on u1 is lost
        drv(1, 32'h8000, 1, 0, 0, 3'b000);
        @(posedge Clk); #1;
        chk("rm_busy_pre", {31'd0, busy[1]}, 32'h1);
        Reset_n = 1'b0;
        clr_all();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rm_nzp", {29'd0, nzp[i]}, 32'h2);
            chk("rm_ben", {31'd0, ben[i]}, 32'h0);
            chk("rm_busy", {31'd0, busy[i]}, 32'h0);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        ex("rm_post1", 1, 0, 1, 3'b010); ex("rm_post2", 1, 0, 2, 3'b010);
        ex("rm_post_busy", 1, 2, 1, 3'b000);
        repeat (4) step();
        chk("sb_drain2", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nzp_cc_unit.md
Name: nzp_cc_unit

Overview:
- Parametrised successor to the combinational NZP generator: a registered condition-code unit for the LC-3 datapath.
- Derives N/Z/P from a WIDTH-bit result bus and holds them in the CC register under LD_CC.
- Evaluates the branch-enable (BEN) flag from IR[11:9] under LD_BEN.
- Adds an unsigned compare mode and an optional input pipeline stage for timing closure on wide buses.
- Sits between the shared data bus and the control FSM.

Parameters:
- WIDTH, 16, width of the result bus sampled for condition codes; legal range 2 to 64.
- PIPE, 0, 0 = flags computed directly from D_in; 1 = D_in/LD_CC/UNSIGNED registered first, adding one cycle of latency.
- CC_RESET, 3'b010, NZP register value after reset (Z set by default).

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- D_in  input  WIDTH  result bus value to classify.
- LD_CC  input  1  load NZP register from D_in.
- UNSIGNED  input  1  1 = treat D_in as unsigned (N never set); sampled with LD_CC.
- IR_nzp  input  3  IR[11:9] branch condition mask {n,z,p}.
- LD_BEN  input  1  load BEN register.
- NZP_out  output  3  registered {N,Z,P}; exactly one bit is set at all times.
- BEN  output  1  registered branch-enable.
- cc_busy  output  1  PIPE=1 only: a CC update is captured but not yet committed; tied 0 when PIPE=0.

Behaviour:
- Reset (asynchronous assert, synchronous-to-Clk release):
  - NZP_out = CC_RESET, BEN = 0, cc_busy = 0.
  - Any pending pipeline-stage contents are discarded.
- Classification (combinational, on the stage input):
  - Signed mode: N = D[WIDTH-1]; Z = (D == 0); P = otherwise.
  - Unsigned mode: N = 0; Z = (D == 0); P = (D != 0).
  - Output is always one-hot; the most-negative value (MSB set, rest 0) gives N in signed mode and P in unsigned mode.
- PIPE=0:
  - LD_CC high at edge k: NZP_out reflects D_in/UNSIGNED sampled at edge k, visible after edge k. Latency 1.
- PIPE=1:
  - Edge k: stage captures D_in, UNSIGNED, and LD_CC (as a pending bit). cc_busy = pending bit.
  - Edge k+1: if pending, NZP_out is updated from the stage. Latency 2.
  - Back-to-back LD_CC on consecutive cycles: each update commits in order, one per cycle; no update is dropped.
  - LD_CC low: stage pending bit clears on the next edge; NZP_out holds.
- BEN:
  - On an edge with LD_BEN = 1: BEN <= |(IR_nzp & NZP_out), using the NZP register value before that edge.
  - Otherwise BEN holds.
- Simultaneous events:
  - LD_BEN and a committing CC update on the same edge: BEN uses the old NZP (matches LC-3 FSM state ordering).
  - In PIPE=1, control must not rely on BEN until cc_busy = 0. The unit does not stall.
- IR_nzp = 000: BEN loads 0. IR_nzp = 111: BEN loads 1 (unconditional branch).
- Reset asserted mid-pipeline: the pending update is lost, and NZP_out returns to CC_RESET immediately (asynchronously).
- Without LD_CC, NZP_out never changes, regardless of D_in activity.

Test Plan:
- Reset: assert Reset_n = 0 mid-cycle with LD_CC pending (PIPE=1) -> NZP_out = 010, BEN = 0, and cc_busy = 0 immediately; no commit after release.
- Signed classify, WIDTH=16, PIPE=0: LD_CC with D_in = 16'h8000, then 16'h0000, then 16'h0001 -> NZP_out = 100, 010, 001 on successive cycles.
- Unsigned mode: UNSIGNED = 1, LD_CC, D_in = 16'hFFFF -> NZP_out = 001. Then D_in = 0 -> 010.
- BEN ordering: NZP_out = 001; same edge LD_CC with D_in = 16'h8000 and LD_BEN with IR_nzp = 001 -> BEN = 1 and NZP_out = 100. Next LD_BEN with IR_nzp = 001 -> BEN = 0.
- PIPE=1 back-to-back: LD_CC for three consecutive cycles with D_in = 5, 0, -3 -> NZP_out = 001, 010, 100 on edges k+1..k+3; cc_busy high on cycles k..k+2, then low.
- WIDTH=32, signed: D_in = 32'h0001_0000 -> P (not Z). D_in = 32'h8000_0000 -> N. IR_nzp = 111 gives BEN = 1 for every NZP value.
